// File: rtl/uart_rx.sv
// UART receiver: 8N1 frames, LSB first, 7 data bits kept (bit 7 is always 0
// from the paired transmitter and is dropped). A single-entry holding register
// with a level valid flag, a read acknowledge, and sticky overrun reporting.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | line idle, waiting for a falling edge on the synchronized rx
// START | timing to the middle of the start bit to reject glitches
// DATA  | sampling the 8 data bits at their midpoints, LSB first
// STOP  | sampling the stop bit; high completes the character
// BREAK | stop bit was low; waiting for the line to return high
module uart_rx #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       res_n,
    input  logic       rx,
    input  logic       rd,
    output logic [6:0] data,
    output logic       valid,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic            rx_meta;
    logic            rx_sync;
    logic [CW-1:0]   cnt_clk;
    logic [CW-1:0]   cnt_clk_nxt;
    logic [2:0]      cnt_bit;
    logic [2:0]      cnt_bit_nxt;
    logic [6:0]      shift;
    logic [6:0]      shift_nxt;
    logic [6:0]      data_nxt;
    logic            valid_nxt;
    logic            overrun_nxt;
    logic            frame_err_nxt;
    logic            char_done;

    // Two-flop synchronizer; both stages reset to the idle-high line level.
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
        end
    end

    // State, counters, shift register and output registers.
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            state     <= IDLE;
            cnt_clk   <= '0;
            cnt_bit   <= '0;
            shift     <= '0;
            data      <= '0;
            valid     <= 1'b0;
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt_clk   <= cnt_clk_nxt;
            cnt_bit   <= cnt_bit_nxt;
            shift     <= shift_nxt;
            data      <= data_nxt;
            valid     <= valid_nxt;
            overrun   <= overrun_nxt;
            frame_err <= frame_err_nxt;
        end
    end

    // Next-state, bit timing and holding-register update.
    always_comb begin
        state_nxt     = state;
        cnt_clk_nxt   = cnt_clk;
        cnt_bit_nxt   = cnt_bit;
        shift_nxt     = shift;
        data_nxt      = data;
        valid_nxt     = valid;
        overrun_nxt   = overrun;
        frame_err_nxt = 1'b0;
        char_done     = 1'b0;

        case (state)
            IDLE: begin
                if (!rx_sync) begin
                    cnt_clk_nxt = '0;
                    state_nxt   = START;
                end
            end
            START: begin
                if (cnt_clk == CNT_HALF) begin
                    cnt_clk_nxt = '0;
                    if (!rx_sync) begin
                        cnt_bit_nxt = '0;
                        state_nxt   = DATA;
                    end else begin
                        state_nxt   = IDLE;
                    end
                end else begin
                    cnt_clk_nxt = cnt_clk + CW'(1);
                end
            end
            DATA: begin
                if (cnt_clk == CNT_LAST) begin
                    cnt_clk_nxt = '0;
                    // Bit 7 is sampled for timing but never stored.
                    if (cnt_bit != 3'd7) begin
                        shift_nxt[cnt_bit] = rx_sync;
                    end
                    if (cnt_bit == 3'd7) begin
                        cnt_bit_nxt = '0;
                        state_nxt   = STOP;
                    end else begin
                        cnt_bit_nxt = cnt_bit + 3'd1;
                    end
                end else begin
                    cnt_clk_nxt = cnt_clk + CW'(1);
                end
            end
            STOP: begin
                if (cnt_clk == CNT_LAST) begin
                    cnt_clk_nxt = '0;
                    if (rx_sync) begin
                        char_done = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        frame_err_nxt = 1'b1;
                        state_nxt     = BREAK;
                    end
                end else begin
                    cnt_clk_nxt = cnt_clk + CW'(1);
                end
            end
            BREAK: begin
                if (rx_sync) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        // A completing character beats a same-cycle read: the new data is
        // held and overrun only flags data that was never acknowledged.
        if (char_done) begin
            data_nxt    = shift;
            valid_nxt   = 1'b1;
            overrun_nxt = valid & ~rd;
        end else if (valid && rd) begin
            valid_nxt   = 1'b0;
            overrun_nxt = 1'b0;
        end
    end

    // Busy whenever a frame or break is in progress.
    always_comb begin
        busy = (state != IDLE);
    end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at 16 clocks per bit: directed corner
// sequences, a constant vector table, and a randomized run against a
// character-level model of the holding register.
module tb_uart_rx;

    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       res_n;
    logic       rx;
    logic       rd;
    logic [6:0] data;
    logic       valid;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    int passed = 0;
    int total  = 0;

    int   cyc       = 0;
    int   start_cyc = 0;
    int   rise_cyc  = 0;
    int   rise_cnt  = 0;
    int   fe_cnt    = 0;
    int   busy_cnt  = 0;
    logic valid_q   = 1'b0;

    typedef struct {
        logic [7:0] ch;
        logic       rd_first;
        logic [6:0] exp_data;
        logic       exp_valid;
        logic       exp_ovr;
    } vec_t;

    vec_t vecs [6];

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk       (clk),
        .res_n     (res_n),
        .rx        (rx),
        .rd        (rd),
        .data      (data),
        .valid     (valid),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Clock-edge counter used as the timing reference.
    always @(posedge clk) cyc <= cyc + 1;

    // Output activity monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (valid && !valid_q) begin
            rise_cyc <= cyc;
            rise_cnt <= rise_cnt + 1;
        end
        valid_q <= valid;
        if (frame_err) fe_cnt <= fe_cnt + 1;
        if (busy) busy_cnt <= busy_cnt + 1;
    end

    // Hard time limit so the run always ends.
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic sample();
        @(negedge clk);
        #1;
    endtask

    // Called at a rising edge; ends at the rising edge closing the stop bit.
    task automatic send_frame(input logic [7:0] b, input logic stop_val, input int stop_cycles);
        #1 rx = 1'b0;
        start_cyc = cyc;
        repeat (CPB) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            #1 rx = b[i];
            repeat (CPB) @(posedge clk);
        end
        #1 rx = stop_val;
        repeat (stop_cycles) @(posedge clk);
    endtask

    task automatic pulse_rd();
        #1 rd = 1'b1;
        @(posedge clk);
        #1 rd = 1'b0;
        @(posedge clk);
    endtask

    logic [7:0] b;
    int         gap;
    int         do_rd;
    int         base_a;
    int         base_b;
    logic       m_valid;
    logic       m_ovr;
    logic [6:0] m_data;

    initial begin
        vecs[0] = '{8'h41, 1'b0, 7'h41, 1'b1, 1'b0};
        vecs[1] = '{8'h12, 1'b0, 7'h12, 1'b1, 1'b1};
        vecs[2] = '{8'h34, 1'b1, 7'h34, 1'b1, 1'b0};
        vecs[3] = '{8'h7F, 1'b0, 7'h7F, 1'b1, 1'b1};
        vecs[4] = '{8'hC5, 1'b1, 7'h45, 1'b1, 1'b0};
        vecs[5] = '{8'h80, 1'b0, 7'h00, 1'b1, 1'b1};

        // Reset values, checked before any clock edge.
        res_n = 1'b0;
        rx    = 1'b1;
        rd    = 1'b0;
        #3;
        check("reset_data", 32'(data), 32'h0);
        check("reset_valid", 32'(valid), 32'h0);
        check("reset_frame_err", 32'(frame_err), 32'h0);
        check("reset_overrun", 32'(overrun), 32'h0);
        check("reset_busy", 32'(busy), 32'h0);
        repeat (2) @(posedge clk);
        #1 res_n = 1'b1;
        @(posedge clk);

        // rd with nothing held has no effect.
        #1 rd = 1'b1;
        repeat (3) @(posedge clk);
        #1 rd = 1'b0;
        sample();
        check("rd_idle_valid", 32'(valid), 32'h0);
        check("rd_idle_overrun", 32'(overrun), 32'h0);
        @(posedge clk);

        // Start-bit glitch: 4 low cycles, then back high.
        base_a = busy_cnt;
        base_b = rise_cnt;
        #1 rx = 1'b0;
        repeat (4) @(posedge clk);
        #1 rx = 1'b1;
        repeat (20) @(posedge clk);
        sample();
        check("glitch_busy_cycles", 32'(busy_cnt - base_a), 32'd8);
        check("glitch_busy_low", 32'(busy), 32'h0);
        check("glitch_no_valid", 32'(rise_cnt - base_b), 32'd0);
        @(posedge clk);

        // Single character with exact completion timing.
        base_a = fe_cnt;
        send_frame(8'h41, 1'b1, CPB);
        sample();
        check("t41_latency", 32'(rise_cyc - start_cyc), 32'(3 + CPB / 2 + 9 * CPB));
        check("t41_data", 32'(data), 32'h41);
        check("t41_valid", 32'(valid), 32'h1);
        check("t41_overrun", 32'(overrun), 32'h0);
        check("t41_frame_err", 32'(fe_cnt - base_a), 32'd0);
        @(posedge clk);
        pulse_rd();
        sample();
        check("t41_rd_valid", 32'(valid), 32'h0);
        check("t41_rd_data_hold", 32'(data), 32'h41);
        @(posedge clk);

        // Stop bit held low for 40 cycles: frame error and break.
        base_a = fe_cnt;
        base_b = rise_cnt;
        send_frame(8'h55, 1'b0, 40);
        sample();
        check("brk_fe_pulses", 32'(fe_cnt - base_a), 32'd1);
        check("brk_busy_held", 32'(busy), 32'h1);
        check("brk_no_valid", 32'(rise_cnt - base_b), 32'd0);
        @(posedge clk);
        rx = 1'b1;
        @(posedge clk);
        sample();
        check("brk_busy_sync_delay", 32'(busy), 32'h1);
        @(posedge clk);
        sample();
        check("brk_exit_idle", 32'(busy), 32'h0);
        check("brk_valid_low", 32'(valid), 32'h0);
        @(posedge clk);

        // Constant vector table.
        base_a = fe_cnt;
        for (int i = 0; i < 6; i++) begin
            if (vecs[i].rd_first) pulse_rd();
            repeat (3) @(posedge clk);
            send_frame(vecs[i].ch, 1'b1, CPB);
            sample();
            check($sformatf("vec%0d_data", i), 32'(data), 32'(vecs[i].exp_data));
            check($sformatf("vec%0d_valid", i), 32'(valid), 32'(vecs[i].exp_valid));
            check($sformatf("vec%0d_overrun", i), 32'(overrun), 32'(vecs[i].exp_ovr));
            @(posedge clk);
        end
        check("vec_no_frame_err", 32'(fe_cnt - base_a), 32'd0);
        pulse_rd();
        sample();
        check("vec_rd_clears_valid", 32'(valid), 32'h0);
        check("vec_rd_clears_overrun", 32'(overrun), 32'h0);
        @(posedge clk);

        // Back-to-back 0x12, 0x34 without reading.
        send_frame(8'h12, 1'b1, CPB);
        send_frame(8'h34, 1'b1, CPB);
        sample();
        check("b2b_data", 32'(data), 32'h34);
        check("b2b_valid", 32'(valid), 32'h1);
        check("b2b_overrun", 32'(overrun), 32'h1);
        @(posedge clk);
        pulse_rd();
        sample();
        check("b2b_rd_valid", 32'(valid), 32'h0);
        check("b2b_rd_overrun", 32'(overrun), 32'h0);
        check("b2b_rd_data_hold", 32'(data), 32'h34);
        @(posedge clk);

        // Read in the exact cycle the third character completes.
        fork
            begin
                send_frame(8'h11, 1'b1, CPB);
                send_frame(8'h22, 1'b1, CPB);
                send_frame(8'h33, 1'b1, CPB);
            end
            begin
                repeat (2 * 10 * CPB + CPB / 2 + 9 * CPB + 2) @(posedge clk);
                #1 rd = 1'b1;
                @(posedge clk);
                #1 rd = 1'b0;
            end
        join
        sample();
        check("race_data", 32'(data), 32'h33);
        check("race_valid", 32'(valid), 32'h1);
        check("race_overrun", 32'(overrun), 32'h0);
        @(posedge clk);
        pulse_rd();

        // Randomized frames against the character-level model.
        m_valid = 1'b0;
        m_ovr   = 1'b0;
        m_data  = 7'h33;
        base_a  = fe_cnt;
        for (int n = 0; n < 12; n++) begin
            b     = 8'($urandom);
            gap   = int'($urandom_range(0, 6));
            do_rd = int'($urandom_range(0, 1));
            if (do_rd != 0) begin
                pulse_rd();
                if (m_valid) begin
                    m_valid = 1'b0;
                    m_ovr   = 1'b0;
                end
            end
            repeat (gap) @(posedge clk);
            send_frame(b, 1'b1, CPB);
            if (m_valid) m_ovr = 1'b1;
            m_data  = b[6:0];
            m_valid = 1'b1;
            sample();
            check($sformatf("rnd%0d_data", n), 32'(data), 32'(m_data));
            check($sformatf("rnd%0d_valid", n), 32'(valid), 32'(m_valid));
            check($sformatf("rnd%0d_overrun", n), 32'(overrun), 32'(m_ovr));
            @(posedge clk);
        end
        check("rnd_no_frame_err", 32'(fe_cnt - base_a), 32'd0);

        // Load non-zero outputs, then reset in the middle of data bit 3 of 0x7F.
        send_frame(8'h5A, 1'b1, CPB);
        send_frame(8'h3C, 1'b1, CPB);
        sample();
        check("pre_rst_overrun", 32'(overrun), 32'h1);
        @(posedge clk);
        #1 rx = 1'b0;
        repeat (CPB) @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            #1 rx = 1'b1;
            repeat (CPB) @(posedge clk);
        end
        #1 rx = 1'b1;
        repeat (CPB / 2) @(posedge clk);
        #1 res_n = 1'b0;
        #2;
        check("midrst_data", 32'(data), 32'h0);
        check("midrst_valid", 32'(valid), 32'h0);
        check("midrst_overrun", 32'(overrun), 32'h0);
        check("midrst_frame_err", 32'(frame_err), 32'h0);
        check("midrst_busy", 32'(busy), 32'h0);
        repeat (2) @(posedge clk);
        #1 res_n = 1'b1;
        base_b = rise_cnt;
        repeat (30) @(posedge clk);
        sample();
        check("postrst_idle", 32'(busy), 32'h0);
        check("postrst_no_valid", 32'(rise_cnt - base_b), 32'd0);
        @(posedge clk);
        send_frame(8'h2A, 1'b1, CPB);
        sample();
        check("postrst_data", 32'(data), 32'h2A);
        check("postrst_valid", 32'(valid), 32'h1);
        check("postrst_overrun", 32'(overrun), 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
